// File: rtl/data_mem_hs.sv
// Handshaked word-addressed data memory with per-byte write enables, wait states,
// and range/conflict error reporting for the processor load/store path.
module data_mem_hs #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     write_data,
  input  logic [DATA_W/8-1:0]   byte_en,
  output logic [DATA_W-1:0]     read_data,
  output logic                  mem_ready,
  output logic                  mem_err,
  output logic                  mem_busy
);

  localparam int NB = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              rd_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     be_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              commit;
  logic              addr_ok;
  logic              conflict;
  logic              do_write;
  logic [IDX_W-1:0]  idx;

  // The access happens on the last WAIT edge; everything is taken from the latched request.
  assign commit   = (state == S_WAIT) && (cnt == 4'd0);
  assign addr_ok  = ({1'b0, addr_q} < DEPTH_EXT);
  assign conflict = rd_q & wr_q;
  assign idx      = addr_q[IDX_W-1:0];
  assign do_write = commit & wr_q & ~rd_q & addr_ok;
  assign mem_busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < NB; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      read_data <= '0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_rd | mem_wr) begin
            rd_q    <= mem_rd;
            wr_q    <= mem_wr;
            addr_q  <= addr;
            wdata_q <= write_data;
            be_q    <= byte_en;
            cnt     <= WAIT_LOAD;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            mem_ready <= 1'b1;
            mem_err   <= conflict | ~addr_ok;
            if (!conflict && rd_q) begin
              read_data <= addr_ok ? mem[idx] : '0;
            end
            state <= S_DONE;
          end
        end
        S_DONE: begin
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
